prog_clock_divider: RTL and testbench
=====================================

Name: prog_clock_divider

Overview:
- Multi-channel, runtime-programmable clock divider and tick generator.
- Each channel has its own divide value, output mode and enable, and produces a one-cycle TICK strobe and a DIV_CLK output.
- Divide value and mode are reconfigured through a shadow register that is applied only at a period boundary, so running periods are never corrupted.
- Feeds timers, debouncers and display scanning in the locker design.

Parameters:
CHANNELS, 2, number of independent divider channels (1..16)
WIDTH, 16, counter and divide-value width; max divide value 2^WIDTH-1
CH_W, 1, width of CFG_CH; must satisfy 2^CH_W >= CHANNELS
DEFAULT_DIV, 1000, active divide value of every channel after reset; must be < 2^WIDTH
DEFAULT_MODE, 0, mode of every channel after reset; 0 = pulse, 1 = square

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
EN  in  CHANNELS  per-channel run enable, level
CFG_WE  in  1  one-cycle configuration write strobe
CFG_CH  in  CH_W  channel index for the write
CFG_DIV  in  WIDTH  new divide value D
CFG_MODE  in  1  new mode: 0 = pulse, 1 = square
CFG_PENDING  out  CHANNELS  shadow written but not yet applied
TICK  out  CHANNELS  one-cycle strobe, once per period
DIV_CLK  out  CHANNELS  divided output; in pulse mode equals TICK, in square mode a registered square wave

Behaviour:
- Reset (RST_N low, asynchronous, may occur mid-operation):
  - All counters = 0; TICK = 0; DIV_CLK = 0; CFG_PENDING = 0.
  - Active D = DEFAULT_DIV and active mode = DEFAULT_MODE on every channel.
  - Shadow registers = the active values.
- Per channel:
  - cnt is WIDTH bits. D is the active divide value. H = floor(D/2).
  - A wrap is the condition EN=1 and cnt == D-1.
- EN low: at the next edge cnt <= 0, TICK <= 0, DIV_CLK <= 0. Re-enabling restarts from cnt 0, so the first TICK arrives exactly D cycles after EN rises.
- EN high, D >= 1:
  - cnt_next = 0 on wrap, otherwise cnt+1. No other wrap-around: cnt never exceeds D-1.
  - TICK <= wrap. TICK is therefore high during the cycle in which cnt = 0 after a wrap; period D cycles, width 1 cycle.
  - Square mode: DIV_CLK <= (cnt_next < H). After the first enabled edge DIV_CLK equals (cnt < H): high H cycles, low D-H cycles.
  - D = 1: TICK is high every cycle; in square mode DIV_CLK stays 0 (H = 0).
- D = 0: channel idle. cnt held at 0; TICK = 0; DIV_CLK = 0 regardless of EN.
- Configuration:
  - CFG_WE=1 with CFG_CH < CHANNELS writes CFG_DIV and CFG_MODE into the shadow register of channel CFG_CH and sets CFG_PENDING[ch].
  - CFG_CH >= CHANNELS: the write is ignored.
  - A write while pending overwrites the shadow; the last write wins.
- Apply (active <= shadow, CFG_PENDING[ch] <= 0) happens at the first edge where any of these holds:
  - a wrap occurs on that channel (applied to the next period);
  - EN[ch] = 0;
  - active D = 0.
- Write on the same edge as a wrap on that channel: the incoming value is applied directly at this boundary and CFG_PENDING stays 0.
- A mode change takes effect with the first period after apply. cnt is not reset by apply.
- Channels are fully independent. Simultaneous wraps on all channels are legal.

Test Plan:
- Reset defaults: reset with DEFAULT_DIV=4, DEFAULT_MODE=0, then EN[0]=1 at cycle 0 -> TICK[0] high in cycles 4, 8, 12; DIV_CLK[0] identical to TICK[0]; TICK[1] stays 0 while EN[1]=0.
- Square waves: square mode with D=5 -> DIV_CLK high 2 cycles, low 3 cycles, repeating; with D=6 -> 3 high, 3 low; with D=1 -> TICK constantly 1 and DIV_CLK 0.
- Deferred reconfiguration: channel running D=8, write D=3 at cnt=2 -> CFG_PENDING=1 until the wrap at cnt=7. The next TICK follows at 8-cycle spacing, then 3-cycle spacing. A second write D=5 before the wrap -> 5 is applied, not 3.
- Boundary cases:
  - Write coincident with a wrap -> applied immediately, PENDING never rises.
  - Write with CFG_CH=3 when CHANNELS=2 -> no state change.
  - Write D=0 -> after apply, outputs stuck 0; a subsequent write D=4 is applied on the next edge.
- Enable and reset mid-period: EN dropped mid-period -> next edge cnt=0 and outputs 0; re-enable gives first TICK D cycles later. RST_N pulsed low mid-period, asynchronous to CLK -> outputs and PENDING clear without waiting for an edge, and D returns to DEFAULT_DIV.

Source files
------------

// File: rtl/prog_clock_divider.sv
// ---------------------------------------------------------------------------
// prog_clock_divider
//
// Multi-channel, runtime-programmable clock divider and tick generator.
// Each channel counts system clock cycles up to its active divide value D.
// It produces a one-cycle TICK strobe per period and a DIV_CLK output. In
// pulse mode DIV_CLK is a copy of TICK. In square mode DIV_CLK is a
// registered square wave that is high for floor(D/2) cycles of each period.
//
// A configuration write lands in a per-channel shadow register. The shadow
// is copied into the active register only at a period boundary, so a
// running period is never cut short or stretched. A channel that is
// disabled or idle (D = 0) has no period to protect, so it takes the shadow
// on the next edge.
//
// Parameters
//   CHANNELS     number of independent channels (1..16)
//   WIDTH        counter / divide-value width
//   CH_W         width of CFG_CH, 2**CH_W >= CHANNELS
//   DEFAULT_DIV  active divide value after reset (< 2**WIDTH)
//   DEFAULT_MODE active mode after reset (0 = pulse, 1 = square)
//
// Ports
//   CLK          system clock, rising edge
//   RST_N        asynchronous active-low reset
//   EN           per-channel run enable (level)
//   CFG_WE       one-cycle configuration write strobe
//   CFG_CH       channel index of the write; out-of-range writes are dropped
//   CFG_DIV      new divide value
//   CFG_MODE     new mode (0 = pulse, 1 = square)
//   CFG_PENDING  per channel: shadow written but not yet applied
//   TICK         per channel: one-cycle strobe, once per period
//   DIV_CLK      per channel: divided clock output
// ---------------------------------------------------------------------------
module prog_clock_divider #(
    parameter int CHANNELS     = 2,
    parameter int WIDTH        = 16,
    parameter int CH_W         = 1,
    parameter int DEFAULT_DIV  = 1000,
    parameter bit DEFAULT_MODE = 1'b0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CHANNELS-1:0] EN,
    input  logic                CFG_WE,
    input  logic [CH_W-1:0]     CFG_CH,
    input  logic [WIDTH-1:0]    CFG_DIV,
    input  logic                CFG_MODE,
    output logic [CHANNELS-1:0] CFG_PENDING,
    output logic [CHANNELS-1:0] TICK,
    output logic [CHANNELS-1:0] DIV_CLK
);

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_e;

    // One channel's programmable settings; active and shadow share this shape.
    typedef struct packed {
        logic [WIDTH-1:0] div;
        mode_e            mode;
    } cfg_t;

    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam mode_e            RST_MODE = mode_e'(DEFAULT_MODE);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    cfg_t                active_q [CHANNELS];
    cfg_t                active_d [CHANNELS];
    cfg_t                shadow_q [CHANNELS];
    cfg_t                shadow_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] pending_d;
    logic [CHANNELS-1:0] tick_q;
    logic [CHANNELS-1:0] tick_d;
    logic [CHANNELS-1:0] div_clk_q;
    logic [CHANNELS-1:0] div_clk_d;

    // Per-channel decode of the current cycle
    logic [CHANNELS-1:0] run;       // enabled with a non-zero divide value
    logic [CHANNELS-1:0] wrap;      // last cycle of the current period
    logic [CHANNELS-1:0] cfg_hit;   // configuration write addressed here
    cfg_t                incoming;  // value carried by the write port

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        run           = '0;
        wrap          = '0;
        cfg_hit       = '0;
        incoming.div  = CFG_DIV;
        incoming.mode = mode_e'(CFG_MODE);
        for (int c = 0; c < CHANNELS; c++) begin
            run[c]  = EN[c] && (active_q[c].div != '0);
            wrap[c] = run[c] && (cnt_q[c] == (active_q[c].div - ONE));
            // An index at or beyond CHANNELS matches no channel, which is
            // how out-of-range writes are dropped.
            cfg_hit[c] = CFG_WE && (int'(CFG_CH) == c);
        end
    end

    // -----------------------------------------------------------------------
    // Shadow / active configuration
    // -----------------------------------------------------------------------
    always_comb begin
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (cfg_hit[c] && wrap[c]) begin
                // The write lands exactly on a boundary: take it straight
                // into the active set so the next period already uses it.
                active_d[c]  = incoming;
                shadow_d[c]  = incoming;
                pending_d[c] = 1'b0;
            end else begin
                // Apply points. With nothing pending the shadow equals the
                // active set, so copying it unconditionally is harmless.
                if (wrap[c] || !EN[c] || (active_q[c].div == '0)) begin
                    active_d[c]  = shadow_q[c];
                    pending_d[c] = 1'b0;
                end
                // A new write always ends up pending; the last write wins.
                if (cfg_hit[c]) begin
                    shadow_d[c]  = incoming;
                    pending_d[c] = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Counter and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        tick_d    = '0;
        div_clk_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!run[c]) begin
                // Disabled or D = 0: park at zero with both outputs low.
                cnt_d[c] = '0;
            end else begin
                cnt_d[c]  = wrap[c] ? '0 : (cnt_q[c] + ONE);
                tick_d[c] = wrap[c];
                // active_d differs from active_q only on a wrap, when cnt_d
                // is 0. Using it makes a newly applied D and mode shape the
                // very first cycle of the new period.
                if (active_d[c].mode == MODE_SQUARE) begin
                    div_clk_d[c] = (cnt_d[c] < (active_d[c].div >> 1));
                end else begin
                    div_clk_d[c] = wrap[c];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge regardless of order.
    // NOTE: the per-channel configuration arrays are reset on purpose: the
    // channels must come up running DEFAULT_DIV/DEFAULT_MODE, with the
    // shadow equal to the active set so an idle apply changes nothing.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int c = 0; c < CHANNELS; c++) begin
                active_q[c].div  <= RST_DIV;
                active_q[c].mode <= RST_MODE;
                shadow_q[c].div  <= RST_DIV;
                shadow_q[c].mode <= RST_MODE;
                cnt_q[c]         <= '0;
            end
            pending_q <= '0;
            tick_q    <= '0;
            div_clk_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                active_q[c] <= active_d[c];
                shadow_q[c] <= shadow_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            pending_q <= pending_d;
            tick_q    <= tick_d;
            div_clk_q <= div_clk_d;
        end
    end

    assign CFG_PENDING = pending_q;
    assign TICK        = tick_q;
    assign DIV_CLK     = div_clk_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_prog_clock_divider
//
// Self-checking bench for prog_clock_divider with CHANNELS=2, WIDTH=16,
// CH_W=2, DEFAULT_DIV=4, DEFAULT_MODE=0. A cycle-level reference model
// predicts TICK/DIV_CLK/CFG_PENDING for every edge and queues the
// prediction; it is popped and compared just after the edge. Hand-derived
// expectations are checked on top of that for the key scenarios.
// ---------------------------------------------------------------------------
module tb_prog_clock_divider;

    localparam int CHANNELS = 2;
    localparam int WIDTH    = 16;
    localparam int CH_W     = 2;

    logic                CLK;
    logic                RST_N;
    logic [CHANNELS-1:0] EN;
    logic                CFG_WE;
    logic [CH_W-1:0]     CFG_CH;
    logic [WIDTH-1:0]    CFG_DIV;
    logic                CFG_MODE;
    logic [CHANNELS-1:0] CFG_PENDING;
    logic [CHANNELS-1:0] TICK;
    logic [CHANNELS-1:0] DIV_CLK;

    prog_clock_divider #(
        .CHANNELS    (CHANNELS),
        .WIDTH       (WIDTH),
        .CH_W        (CH_W),
        .DEFAULT_DIV (4),
        .DEFAULT_MODE(1'b0)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .CFG_WE     (CFG_WE),
        .CFG_CH     (CFG_CH),
        .CFG_DIV    (CFG_DIV),
        .CFG_MODE   (CFG_MODE),
        .CFG_PENDING(CFG_PENDING),
        .TICK       (TICK),
        .DIV_CLK    (DIV_CLK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model and scoreboard
    // -----------------------------------------------------------------------
    typedef struct {
        logic [1:0] tick;
        logic [1:0] dclk;
        logic [1:0] pend;
    } exp_t;

    exp_t sb_q[$];

    int unsigned m_cnt  [2];
    int unsigned m_div  [2];
    int unsigned m_sdiv [2];
    bit          m_mode [2];
    bit          m_smode[2];
    bit          m_pend [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_cnt[c]   = 0;
            m_div[c]   = 4;
            m_sdiv[c]  = 4;
            m_mode[c]  = 1'b0;
            m_smode[c] = 1'b0;
            m_pend[c]  = 1'b0;
        end
    endtask

    // Predicts the outputs after the coming edge given this cycle's inputs.
    task automatic model_edge(input logic [1:0] en, input logic we, input logic [1:0] ch,
                              input logic [15:0] dv, input logic md);
        exp_t e;
        bit   hit;
        bit   active;
        bit   at_end;
        for (int c = 0; c < 2; c++) begin
            hit    = we && (int'(ch) == c);
            active = en[c] && (m_div[c] != 0);
            at_end = active && (m_cnt[c] + 1 == m_div[c]);
            if (hit && at_end) begin
                m_div[c] = dv; m_mode[c] = md; m_sdiv[c] = dv; m_smode[c] = md; m_pend[c] = 1'b0;
            end else begin
                if (at_end || !en[c] || m_div[c] == 0) begin
                    m_div[c] = m_sdiv[c]; m_mode[c] = m_smode[c]; m_pend[c] = 1'b0;
                end
                if (hit) begin
                    m_sdiv[c] = dv; m_smode[c] = md; m_pend[c] = 1'b1;
                end
            end
            m_cnt[c]  = (!active || at_end) ? 0 : m_cnt[c] + 1;
            e.tick[c] = at_end;
            if (!active)        e.dclk[c] = 1'b0;
            else if (m_mode[c]) e.dclk[c] = (m_cnt[c] < m_div[c] / 2);
            else                e.dclk[c] = at_end;
            e.pend[c] = m_pend[c];
        end
        sb_q.push_back(e);
    endtask

    // One clock cycle: drive inputs, predict, wait for the edge, compare.
    task automatic step(input logic [1:0] en, input logic we, input logic [1:0] ch,
                        input logic [15:0] dv, input logic md);
        exp_t e;
        EN = en; CFG_WE = we; CFG_CH = ch; CFG_DIV = dv; CFG_MODE = md;
        model_edge(en, we, ch, dv, md);
        @(posedge CLK);
        #1;
        CFG_WE = 1'b0;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("sb_tick", TICK, e.tick);
            check("sb_dclk", DIV_CLK, e.dclk);
            check("sb_pend", CFG_PENDING, e.pend);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reset-default vectors (inputs and hand-derived outputs per cycle)
    // -----------------------------------------------------------------------
    typedef struct {
        logic [1:0]  en;
        logic        we;
        logic [1:0]  ch;
        logic [15:0] dv;
        logic        md;
        logic [1:0]  tick;
        logic [1:0]  dclk;
        logic [1:0]  pend;
    } vec_t;

    vec_t vecs[12];

    // Expected square waves after the first enabled edge, D=5 and D=6.
    bit sq5[12] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0};
    bit sq6[12] = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};

    logic        we_v;
    logic [1:0]  ch_v;
    logic [15:0] dv_v;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // D=4 pulse on channel 0: TICK on edges 4, 8, 12. Row 6 also
        // carries a write to channel 3, which does not exist.
        vecs[0]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[2]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[3]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b01, 2'b01, 2'b00};
        vecs[4]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{2'b01, 1'b1, 2'd3, 16'd2, 1'b1, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[7]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b01, 2'b01, 2'b00};
        vecs[8]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[9]  = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b00, 2'b00, 2'b00};
        vecs[11] = '{2'b01, 1'b0, 2'd0, 16'd0, 1'b0, 2'b01, 2'b01, 2'b00};

        RST_N = 1'b0; EN = '0; CFG_WE = 1'b0; CFG_CH = '0; CFG_DIV = '0; CFG_MODE = 1'b0;
        model_reset();
        #12;
        check("rst_tick", TICK, 2'b00);
        check("rst_dclk", DIV_CLK, 2'b00);
        check("rst_pend", CFG_PENDING, 2'b00);
        #5 RST_N = 1'b1;

        // ---- Reset defaults -------------------------------------------------
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].en, vecs[i].we, vecs[i].ch, vecs[i].dv, vecs[i].md);
            check("tbl_tick", TICK, vecs[i].tick);
            check("tbl_dclk", DIV_CLK, vecs[i].dclk);
            check("tbl_pend", CFG_PENDING, vecs[i].pend);
        end

        // ---- Square waves: ch0 D=5, ch1 D=6, loaded while disabled ---------
        step(2'b00, 1'b1, 2'd0, 16'd5, 1'b1);
        check("sq_pend_a", CFG_PENDING, 2'b01);
        step(2'b00, 1'b1, 2'd1, 16'd6, 1'b1);
        check("sq_pend_b", CFG_PENDING, 2'b10);
        step(2'b00, 1'b0, 2'd0, 16'd0, 1'b0);
        check("sq_pend_c", CFG_PENDING, 2'b00);
        for (int k = 1; k <= 12; k++) begin
            step(2'b11, 1'b0, 2'd0, 16'd0, 1'b0);
            check("sq5_dclk", DIV_CLK[0], sq5[k-1]);
            check("sq6_dclk", DIV_CLK[1], sq6[k-1]);
            check("sq5_tick", TICK[0], (k == 5 || k == 10));
            check("sq6_tick", TICK[1], (k == 6 || k == 12));
        end

        // ---- D=1 square: TICK every cycle, DIV_CLK low ---------------------
        step(2'b00, 1'b1, 2'd0, 16'd1, 1'b1);
        step(2'b00, 1'b0, 2'd0, 16'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step(2'b01, 1'b0, 2'd0, 16'd0, 1'b0);
            check("d1_tick", TICK[0], 1'b1);
            check("d1_dclk", DIV_CLK[0], 1'b0);
        end

        // ---- Deferred reconfiguration on ch0 -------------------------------
        // D=8; write 3 at cnt=2 (edge 3), applied at the wrap on edge 8.
        // Edge 17 write of 8 coincides with a wrap; 3 then 5 written before
        // the next wrap (edge 25), so 5 wins. Edge 37 writes channel 3.
        step(2'b00, 1'b1, 2'd0, 16'd8, 1'b0);
        step(2'b00, 1'b0, 2'd0, 16'd0, 1'b0);
        for (int k = 1; k <= 46; k++) begin
            ch_v = 2'd0;
            dv_v = 16'd0;
            case (k)
                3:       dv_v = 16'd3;
                17:      dv_v = 16'd8;
                19:      dv_v = 16'd3;
                21:      dv_v = 16'd5;
                37:      begin dv_v = 16'd2; ch_v = 2'd3; end
                default: dv_v = 16'd0;
            endcase
            we_v = (dv_v != 16'd0);
            step(2'b01, we_v, ch_v, dv_v, 1'b0);
            check("defer_tick", TICK[0],
                  (k == 8 || k == 11 || k == 14 || k == 17 || k == 25 ||
                   k == 30 || k == 35 || k == 40 || k == 45));
            check("defer_pend", CFG_PENDING[0], ((k >= 3 && k <= 7) || (k >= 19 && k <= 24)));
        end

        // ---- D=0 on ch1, then D=4 applied on the next edge -----------------
        for (int j = 1; j <= 16; j++) begin
            we_v = (j == 1 || j == 9);
            dv_v = (j == 9) ? 16'd4 : 16'd0;
            step(2'b10, we_v, 2'd1, dv_v, 1'b0);
            check("d0_tick", TICK[1], (j == 6 || j == 14));
            check("d0_pend", CFG_PENDING[1], ((j >= 1 && j <= 5) || j == 9));
            if (j >= 7 && j <= 10) check("d0_dclk", DIV_CLK[1], 1'b0);
        end

        // ---- EN dropped mid-period on ch1 (D=4, cnt=2) ---------------------
        for (int i = 1; i <= 9; i++) begin
            step((i == 1) ? 2'b00 : 2'b10, 1'b0, 2'd0, 16'd0, 1'b0);
            check("en_tick", TICK[1], (i == 5 || i == 9));
            if (i == 1) check("en_dclk", DIV_CLK[1], 1'b0);
        end

        // ---- Asynchronous reset mid-period ---------------------------------
        step(2'b00, 1'b1, 2'd0, 16'd1, 1'b0);
        step(2'b00, 1'b1, 2'd1, 16'd9, 1'b0);
        step(2'b11, 1'b0, 2'd0, 16'd0, 1'b0);
        check("pre_rst_pend", CFG_PENDING, 2'b10);
        check("pre_rst_tick", TICK[0], 1'b1);
        check("pre_rst_dclk", DIV_CLK[0], 1'b1);
        #2 RST_N = 1'b0;
        #1;
        check("arst_tick", TICK, 2'b00);
        check("arst_dclk", DIV_CLK, 2'b00);
        check("arst_pend", CFG_PENDING, 2'b00);
        model_reset();
        #3 RST_N = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            step(2'b01, 1'b0, 2'd0, 16'd0, 1'b0);
            check("post_rst_tick", TICK[0], (n == 4 || n == 8));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
